frec_ramp_ctrl: RTL and testbench

Sequencing controller for the SPWM output-frequency register. Arbitrates frequency commands from the front-panel buttons (coarse/fine step) and the UART receiver into a clamped target. It then slews the applied frequency toward that target one hertz at a time. Each new value is released to the SPWM generator only on a carrier-period boundary, so the sine table never sees a mid-period frequency change. It sits between the button/UART front end and the SPWM carrier/sine generator, and replaces direct writes to the frequency register.

---
 rtl/spwm_pkg.sv | 30 +++
 rtl/frec_cmd_arb.sv | 58 +++++
 rtl/frec_ramp_ctrl.sv | 126 ++++++++++++
 tb/tb_frec_ramp_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// Shared definitions for the SPWM frequency path: legal frequency range,
// button step sizes, the frequency type and the slew FSM encoding.
package spwm_pkg;

  localparam int F_DEFAULT = 60;
  localparam int F_MIN     = 1;
  localparam int F_MAX     = 120;
  localparam int STEP_FINE = 10;

  typedef logic [7:0] freq_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    WAIT_SYNC = 2'd2
  } slew_state_t;

  // Saturate a 9-bit step result into [F_MIN, F_MAX]; borrow marks an
  // underflowed subtraction, which always lands on F_MIN.
  function automatic freq_t sat_freq(input logic [8:0] v, input logic borrow);
    if (borrow || (v < 9'(F_MIN))) begin
      return freq_t'(F_MIN);
    end else if (v > 9'(F_MAX)) begin
      return freq_t'(F_MAX);
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/frec_cmd_arb.sv
// Command arbiter: picks the frequency command for this cycle (UART or
// buttons), applies the 9-bit saturating step, and flags discarded commands.
module frec_cmd_arb
  import spwm_pkg::*;
(
  input  logic [7:0] target,
  input  logic       Selec,
  input  logic       Aumenta,
  input  logic       Disminuye,
  input  logic       Fino,
  input  logic       rx_valid,
  input  logic [7:0] Rx,
  output logic [7:0] next_target,
  output logic       target_we,
  output logic       reject
);

  logic [8:0] step;
  logic [8:0] sum;
  logic [8:0] diff;
  logic       borrow;

  // Step arithmetic is carried in 9 bits so neither direction can wrap.
  always_comb begin
    step   = Fino ? 9'(STEP_FINE) : 9'd1;
    sum    = {1'b0, target} + step;
    diff   = {1'b0, target} - step;
    borrow = ({1'b0, target} < step);
  end

  // Fixed priority: UART owns the target when Selec=1, buttons otherwise.
  always_comb begin
    next_target = target;
    target_we   = 1'b0;
    reject      = 1'b0;
    if (Selec) begin
      if (rx_valid) begin
        if ((Rx >= 8'(F_MIN)) && (Rx <= 8'(F_MAX))) begin
          next_target = Rx;
          target_we   = 1'b1;
        end else begin
          reject = 1'b1;
        end
      end
    end else begin
      if (Aumenta && Disminuye) begin
        reject = 1'b1;
      end else if (Aumenta) begin
        next_target = sat_freq(sum, 1'b0);
        target_we   = 1'b1;
      end else if (Disminuye) begin
        next_target = sat_freq(diff, borrow);
        target_we   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frec_ramp_ctrl.sv
// Frequency slew controller: holds the clamped target and walks the applied
// frequency toward it 1 Hz at a time, releasing each new value to the SPWM
// generator only on a carrier-period boundary.
//
// Strobe semantics: Aumenta, Disminuye, rx_valid and pwm_sync are one-cycle
// strobes sampled on the rising clock edge with no back-pressure; a strobe
// that is not acted on in its cycle is gone. frec_load and cmd_reject are
// one-cycle strobes produced the same way.
module frec_ramp_ctrl
  import spwm_pkg::*;
#(
  parameter int RAMP_DIV = 1000
) (
  input  logic       clock,
  input  logic       Restablecer,
  input  logic       Aumenta,
  input  logic       Disminuye,
  input  logic       Fino,
  input  logic       Selec,
  input  logic       rx_valid,
  input  logic [7:0] Rx,
  input  logic       pwm_sync,
  output logic [7:0] Frec,
  output logic       frec_load,
  output logic       ramping,
  output logic       cmd_reject,
  output logic [1:0] slew_state
);

  localparam int            PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  slew_state_t   state;
  slew_state_t   state_next;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [7:0]    target;
  logic [7:0]    arb_target;
  logic          arb_we;
  logic          arb_reject;
  logic [7:0]    frec_next;
  logic          load_next;

  frec_cmd_arb u_arb (
    .target      (target),
    .Selec       (Selec),
    .Aumenta     (Aumenta),
    .Disminuye   (Disminuye),
    .Fino        (Fino),
    .rx_valid    (rx_valid),
    .Rx          (Rx),
    .next_target (arb_target),
    .target_we   (arb_we),
    .reject      (arb_reject)
  );

  // Slew FSM next state, prescaler and frequency update. Target changes
  // during a ramp leave the prescaler running; they only steer the next step.
  always_comb begin
    state_next = state;
    presc_next = presc;
    frec_next  = Frec;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        presc_next = '0;
        if (target != Frec) begin
          state_next = WAIT_TICK;
        end
      end
      WAIT_TICK: begin
        if (target == Frec) begin
          state_next = IDLE;
          presc_next = '0;
        end else if (presc == PRESC_LAST) begin
          state_next = WAIT_SYNC;
          presc_next = '0;
        end else begin
          presc_next = presc + PW'(1);
        end
      end
      WAIT_SYNC: begin
        if (pwm_sync) begin
          presc_next = '0;
          if (target == Frec) begin
            state_next = IDLE;
          end else begin
            frec_next  = (target > Frec) ? (Frec + 8'd1) : (Frec - 8'd1);
            load_next  = 1'b1;
            state_next = (frec_next == target) ? IDLE : WAIT_TICK;
          end
        end
      end
      default: begin
        state_next = IDLE;
        presc_next = '0;
      end
    endcase
  end

  // State, target and output registers; reset restores the power-up setting.
  always_ff @(posedge clock) begin
    if (!Restablecer) begin
      state      <= IDLE;
      presc      <= '0;
      target     <= 8'(F_DEFAULT);
      Frec       <= 8'(F_DEFAULT);
      frec_load  <= 1'b0;
      ramping    <= 1'b0;
      cmd_reject <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      Frec       <= frec_next;
      frec_load  <= load_next;
      ramping    <= (state != IDLE);
      cmd_reject <= arb_reject;
      if (arb_we) begin
        target <= arb_target;
      end
    end
  end

  assign slew_state = state;

endmodule

// File: tb/tb_frec_ramp_ctrl.sv
// Bench for frec_ramp_ctrl with a short slew prescaler (RAMP_DIV=4).
module tb_frec_ramp_ctrl;
  import spwm_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       Restablecer = 1'b0;
  logic       Aumenta = 1'b0;
  logic       Disminuye = 1'b0;
  logic       Fino = 1'b0;
  logic       Selec = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] Rx = 8'd0;
  logic       gen_sync = 1'b0;
  logic       man_sync = 1'b0;
  logic       pwm_sync;
  logic [7:0] Frec;
  logic       frec_load;
  logic       ramping;
  logic       cmd_reject;
  logic [1:0] slew_state;

  always #5 clock = ~clock;
  assign pwm_sync = gen_sync | man_sync;

  frec_ramp_ctrl #(.RAMP_DIV(4)) dut (
    .clock      (clock),
    .Restablecer(Restablecer),
    .Aumenta    (Aumenta),
    .Disminuye  (Disminuye),
    .Fino       (Fino),
    .Selec      (Selec),
    .rx_valid   (rx_valid),
    .Rx         (Rx),
    .pwm_sync   (pwm_sync),
    .Frec       (Frec),
    .frec_load  (frec_load),
    .ramping    (ramping),
    .cmd_reject (cmd_reject),
    .slew_state (slew_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int n_loads = 0;
  int cyc = 0;
  int last_load_cyc = -1;
  int min_gap = 1000000;
  int sync_pulses = 0;
  int sync_period = 3;
  logic sync_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] model_frec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Carrier-period strobe generator, driven away from the active edge.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clock);
      if (sync_en && (cnt >= sync_period - 1)) begin
        gen_sync = 1'b1;
        cnt = 0;
        sync_pulses++;
      end else begin
        gen_sync = 1'b0;
        if (sync_en) cnt++;
      end
    end
  end

  // Scoreboard: every frec_load must match the next expected frequency.
  always @(negedge clock) begin
    cyc++;
    if (frec_load) begin
      n_loads++;
      if (last_load_cyc >= 0 && (cyc - last_load_cyc) < min_gap) min_gap = cyc - last_load_cyc;
      last_load_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load actual=%0d required=no load", Frec);
      end else begin
        check("load_value", Frec, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_ramp(input logic [7:0] from, input logic [7:0] to);
    logic [7:0] f = from;
    while (f != to) begin
      f = (to > f) ? f + 8'd1 : f - 8'd1;
      exp_q.push_back(f);
    end
  endtask

  // Called at a negedge; presents one command for one cycle, checks reject.
  task automatic apply_cmd(input logic sel, input logic aum, input logic dis, input logic fino,
                           input logic rxv, input logic [7:0] rx, input logic exp_rej,
                           input string name);
    Selec = sel; Aumenta = aum; Disminuye = dis; Fino = fino; rx_valid = rxv; Rx = rx;
    @(negedge clock);
    Aumenta = 1'b0; Disminuye = 1'b0; rx_valid = 1'b0;
    check({name, "_reject"}, cmd_reject, exp_rej);
  endtask

  task automatic wait_settle(input string name, input int budget);
    int n = 0;
    repeat (3) @(negedge clock);
    while ((exp_q.size() != 0 || ramping) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, "_settled"}, (n < budget), 1);
  endtask

  task automatic wait_load(input logic [7:0] f, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(frec_load && Frec == f) && n < budget);
    check({name, "_load_seen"}, (n < budget), 1);
  endtask

  task automatic reset_dut();
    Restablecer = 1'b0;
    repeat (2) @(negedge clock);
    Restablecer = 1'b1;
    check("rst_frec", Frec, 60);
    check("rst_ramping", ramping, 0);
    check("rst_load", frec_load, 0);
    check("rst_reject", cmd_reject, 0);
    check("rst_state", slew_state, IDLE);
    model_frec = 8'd60;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       selec;
    logic       aum;
    logic       dis;
    logic       fino;
    logic       rxv;
    logic [7:0] rx;
    logic       exp_rej;
    logic [7:0] exp_frec;
  } vec_t;

  vec_t vecs[16];

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, s0, rcnt, n;
    // Sequence starts from Frec = target = 70.
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd69};  // coarse down
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 1'b1, 8'd69};  // UART too high
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b1, 8'd69};  // UART zero
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd55,  1'b0, 8'd55};  // UART 55
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd55};  // button ignored
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd55};  // both ignored, no reject
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd55};  // conflict
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd118, 1'b0, 8'd118};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 8'd120}; // clamp high
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 8'd120}; // saturated
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1,   1'b0, 8'd1};   // F_MIN accepted
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd1};   // clamp low
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd121, 1'b1, 8'd1};   // just above F_MAX
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd120, 1'b0, 8'd120}; // F_MAX accepted
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd110}; // fine down
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd61,  1'b0, 8'd61};  // UART wins over button

    // Reset, then idle under 100 carrier strobes.
    @(negedge clock);
    reset_dut();
    sync_period = 2; sync_en = 1'b1;
    l0 = n_loads; s0 = sync_pulses; rcnt = 0; n = 0;
    while ((sync_pulses - s0) < 100 && n < 400) begin
      @(negedge clock);
      n++;
      if (ramping) rcnt++;
    end
    check("idle_sync_count", (sync_pulses - s0) >= 100, 1);
    check("idle_loads", n_loads - l0, 0);
    check("idle_ramping", rcnt, 0);
    check("idle_frec", Frec, 60);

    // Fine up 60 -> 70 with a strobe every 10 cycles.
    sync_period = 10;
    l0 = n_loads; last_load_cyc = -1; min_gap = 1000000;
    push_ramp(8'd60, 8'd70);
    apply_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, "fine_up");
    wait_load(8'd70, 400, "fine_up");
    check("fine_up_ramping_at_70", ramping, 1);
    @(negedge clock);
    check("fine_up_ramping_after", ramping, 0);
    check("fine_up_frec", Frec, 70);
    check("fine_up_load_count", n_loads - l0, 10);
    check("fine_up_min_gap", (min_gap >= 5), 1);
    model_frec = 8'd70;

    // Table of commands, each slewed to completion.
    sync_period = 3;
    for (int i = 0; i < 16; i++) begin
      push_ramp(model_frec, vecs[i].exp_frec);
      apply_cmd(vecs[i].selec, vecs[i].aum, vecs[i].dis, vecs[i].fino, vecs[i].rxv,
                vecs[i].rx, vecs[i].exp_rej, $sformatf("vec%0d", i));
      wait_settle($sformatf("vec%0d", i), 2000);
      check($sformatf("vec%0d_frec", i), Frec, vecs[i].exp_frec);
      check($sformatf("vec%0d_state", i), slew_state, IDLE);
      model_frec = vecs[i].exp_frec;
    end
    Selec = 1'b0;

    // Direction reversal mid-ramp: 60 -> 70, retarget to 61 at Frec = 63.
    reset_dut();
    push_ramp(8'd60, 8'd63);
    apply_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, "rev_up");
    wait_load(8'd63, 200, "rev_63");
    push_ramp(8'd63, 8'd61);
    apply_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd61, 1'b0, "rev_down");
    wait_settle("rev", 200);
    check("rev_frec", Frec, 61);
    check("rev_queue", exp_q.size(), 0);
    Selec = 1'b0;

    // Cancel while parked in WAIT_SYNC: no load, back to IDLE.
    sync_en = 1'b0;
    repeat (2) @(negedge clock);
    l0 = n_loads;
    apply_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, "cancel_up");
    n = 0;
    while (slew_state != WAIT_SYNC && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("cancel_reach_wait_sync", (n < 50), 1);
    apply_cmd(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, "cancel_down");
    @(negedge clock);
    check("cancel_hold_wait_sync", slew_state, WAIT_SYNC);
    man_sync = 1'b1;
    @(negedge clock);
    man_sync = 1'b0;
    check("cancel_state", slew_state, IDLE);
    check("cancel_load", frec_load, 0);
    check("cancel_frec", Frec, 61);
    repeat (2) @(negedge clock);
    check("cancel_ramping", ramping, 0);
    check("cancel_loads", n_loads - l0, 0);

    // Reset mid-ramp at Frec = 65 heading for 80; the button press is lost.
    sync_period = 3; sync_en = 1'b1;
    push_ramp(8'd61, 8'd65);
    apply_cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd80, 1'b0, "mid_rst_go");
    wait_load(8'd65, 200, "mid_rst_65");
    Restablecer = 1'b0; Selec = 1'b0; Aumenta = 1'b1;
    @(negedge clock);
    Restablecer = 1'b1; Aumenta = 1'b0;
    check("mid_rst_frec", Frec, 60);
    check("mid_rst_ramping", ramping, 0);
    check("mid_rst_load", frec_load, 0);
    check("mid_rst_reject", cmd_reject, 0);
    check("mid_rst_state", slew_state, IDLE);
    l0 = n_loads;
    repeat (30) @(negedge clock);
    check("mid_rst_hold_frec", Frec, 60);
    check("mid_rst_hold_ramping", ramping, 0);
    check("mid_rst_hold_loads", n_loads - l0, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
